// File: rtl/n64_vmode_sched_pkg.sv
// n64_vmode_sched_pkg: shared state encoding and bit indices for video-mode sequencing
package n64_vmode_sched_pkg;
  typedef enum logic [2:0] {
    ST_LOST    = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_REQ     = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_LOCKED  = 3'd4
  } vm_state_e;
  localparam int VINFO_PAL  = 1;
  localparam int VINFO_480I = 0;
  localparam int SYNC_VS    = 3;
  localparam int SYNC_HS    = 1;
  localparam logic [1:0] VINFO_RST = 2'b01;
endpackage

// File: rtl/n64_sync_evgen.sv
// n64_sync_evgen: falling-edge vsync/hsync event decode, qualified by the data-sync strobe
module n64_sync_evgen
  import n64_vmode_sched_pkg::*;
(
  input  logic       nDSYNC,
  input  logic [3:0] Sync_pre,
  input  logic [3:0] Sync_cur,
  output logic       vs_ev,
  output logic       hs_ev
);
  logic unused_bits;
  assign unused_bits = ^{Sync_pre[2], Sync_pre[0], Sync_cur[2], Sync_cur[0]};
  assign vs_ev = !nDSYNC & Sync_pre[SYNC_VS] & !Sync_cur[SYNC_VS];
  assign hs_ev = !nDSYNC & Sync_pre[SYNC_HS] & !Sync_cur[SYNC_HS];
endmodule

// File: rtl/n64_vmode_sched.sv
// n64_vmode_sched: qualifies raw vinfo over several fields, handshakes the change downstream,
// blanks through a settle window and drops lock when the line watchdog expires.
module n64_vmode_sched
  import n64_vmode_sched_pkg::*;
#(
  parameter int unsigned FRAMES_STABLE = 4,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned ACK_TIMEOUT   = 3,
  parameter int unsigned LINE_TIMEOUT  = 400
) (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       nDSYNC,
  input  logic [3:0] Sync_pre,
  input  logic [3:0] Sync_cur,
  input  logic [1:0] vinfo_i,
  input  logic       mode_chg_ack,
  output logic [1:0] vinfo_o,
  output logic       vinfo_valid,
  output logic       blank_o,
  output logic       mode_chg_req,
  output logic       ack_timeout_o
);
  localparam logic [3:0] FS = 4'(FRAMES_STABLE);
  localparam logic [3:0] SF = 4'(SETTLE_FRAMES);
  localparam logic [3:0] AT = 4'(ACK_TIMEOUT);
  localparam logic [8:0] LT = 9'(LINE_TIMEOUT);
  vm_state_e  state_q, state_d;
  logic [1:0] vinfo_q, vinfo_d, cand_q, cand_d;
  logic [3:0] stab_q, stab_d, ato_q, ato_d, set_q, set_d, stab_nx;
  logic [8:0] line_q, line_d;
  logic       valid_q, valid_d, blank_q, blank_d, req_q, req_d, tmo_q, tmo_d;
  logic       vs_ev, hs_ev, sync_lost;
  n64_sync_evgen u_evgen (
    .nDSYNC  (nDSYNC),
    .Sync_pre(Sync_pre),
    .Sync_cur(Sync_cur),
    .vs_ev   (vs_ev),
    .hs_ev   (hs_ev)
  );
  assign sync_lost = (line_q == LT) & !vs_ev;
  assign stab_nx   = (vinfo_i == cand_q) ? stab_q + 4'd1 : 4'd1;
  always_comb begin
    state_d = state_q;
    vinfo_d = vinfo_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    ato_d   = ato_q;
    set_d   = set_q;
    valid_d = valid_q;
    tmo_d   = tmo_q;
    line_d  = vs_ev ? 9'd0 : (hs_ev && line_q != LT) ? line_q + 9'd1 : line_q;
    case (state_q)
      ST_LOST: if (vs_ev) begin
        cand_d  = vinfo_i;
        stab_d  = 4'd1;
        state_d = ST_QUALIFY;
      end
      ST_QUALIFY: if (vs_ev) begin
        cand_d = vinfo_i;
        stab_d = stab_nx;
        // a one-field blip back to the committed mode is not a real change
        if (valid_q && vinfo_i == vinfo_q) state_d = ST_LOCKED;
        else if (stab_nx >= FS) begin
          vinfo_d = vinfo_i;
          valid_d = 1'b0;
          ato_d   = 4'd0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: if (mode_chg_ack) begin
        set_d   = 4'd0;
        state_d = ST_SETTLE;
      end else if (vs_ev) begin
        ato_d = ato_q + 4'd1;
        if (ato_d == AT) begin
          tmo_d   = 1'b1;
          set_d   = 4'd0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: if (vs_ev) begin
        set_d = set_q + 4'd1;
        if (set_d == SF) begin
          valid_d = 1'b1;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: if (vs_ev && vinfo_i != vinfo_q) begin
        cand_d  = vinfo_i;
        stab_d  = 4'd1;
        state_d = ST_QUALIFY;
      end
      default: state_d = ST_LOST;
    endcase
    if (sync_lost) begin
      state_d = ST_LOST;
      valid_d = 1'b0;
    end
    req_d   = state_d == ST_REQ;
    blank_d = (state_d == ST_LOCKED) ? 1'b0 : (state_d == ST_QUALIFY) ? !valid_d : 1'b1;
  end
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      state_q <= ST_LOST;
      vinfo_q <= VINFO_RST;
      cand_q  <= 2'd0;
      stab_q  <= 4'd0;
      ato_q   <= 4'd0;
      set_q   <= 4'd0;
      line_q  <= 9'd0;
      valid_q <= 1'b0;
      blank_q <= 1'b1;
      req_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vinfo_q <= vinfo_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      ato_q   <= ato_d;
      set_q   <= set_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      req_q   <= req_d;
      tmo_q   <= tmo_d;
    end
  end
  assign vinfo_o       = vinfo_q;
  assign vinfo_valid   = valid_q;
  assign blank_o       = blank_q;
  assign mode_chg_req  = req_q;
  assign ack_timeout_o = tmo_q;
endmodule

// File: tb/tb_n64_vmode_sched.sv
// tb_n64_vmode_sched: directed vectors for n64_vmode_sched with hand-computed expectations
module tb_n64_vmode_sched;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       ndsync = 1'b1;
  logic [3:0] sync_pre = 4'hF;
  logic [3:0] sync_cur = 4'hF;
  logic [1:0] vinfo_i = 2'b00;
  logic       ack = 1'b0;
  logic [1:0] vinfo_o;
  logic       valid, blank, req, tmo;
  int         n_run = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  n64_vmode_sched dut (
    .VCLK         (clk),
    .nRST         (nrst),
    .nDSYNC       (ndsync),
    .Sync_pre     (sync_pre),
    .Sync_cur     (sync_cur),
    .vinfo_i      (vinfo_i),
    .mode_chg_ack (ack),
    .vinfo_o      (vinfo_o),
    .vinfo_valid  (valid),
    .blank_o      (blank),
    .mode_chg_req (req),
    .ack_timeout_o(tmo)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ev(input bit vs, input bit hs);
    ndsync   = 1'b0;
    sync_pre = 4'hF;
    sync_cur = {!vs, 1'b1, !hs, 1'b1};
    step();
    ndsync   = 1'b1;
    sync_cur = 4'hF;
  endtask
  task automatic field(input int n_hs);
    repeat (n_hs) ev(1'b0, 1'b1);
    ev(1'b1, 1'b0);
  endtask
  task automatic outs(input string tag, input logic [1:0] vi, input logic v, input logic b,
                      input logic r, input logic t);
    chk({tag, ".vinfo"}, {6'd0, vinfo_o}, {6'd0, vi});
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
    chk({tag, ".blank"}, {7'd0, blank}, {7'd0, b});
    chk({tag, ".req"}, {7'd0, req}, {7'd0, r});
    chk({tag, ".tmo"}, {7'd0, tmo}, {7'd0, t});
  endtask
  initial begin
    step();
    step();
    outs("reset", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    nrst = 1'b1;
    // lock to 00 with a real handshake
    vinfo_i = 2'b00;
    for (int i = 1; i <= 3; i++) field(263);
    outs("qual3", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    field(263);
    outs("req_rise", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (9) step();
    chk("req_hold", {7'd0, req}, 8'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("req_fall", {7'd0, req}, 8'd0);
    field(10);
    outs("settle1", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    field(10);
    outs("locked", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    // glitch reject
    vinfo_i = 2'b10;
    field(10);
    outs("glitch_q", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    vinfo_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      field(10);
      outs("glitch_back", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    // ack high outside REQ is ignored
    ack = 1'b1;
    field(5);
    outs("ack_ign", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    ack = 1'b0;
    // mode change to 11 with ack timeout
    vinfo_i = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      field(10);
      outs("chg_qual", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    field(10);
    outs("chg_req", 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    field(10);
    field(10);
    outs("ato2", 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    field(10);
    outs("ato3", 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    field(10);
    outs("ato_set1", 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    field(10);
    outs("ato_lock", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    // reset in the middle of a request
    vinfo_i = 2'b00;
    for (int i = 0; i < 4; i++) field(10);
    chk("pre_rst_req", {7'd0, req}, 8'd1);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    outs("rst_req", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    // relock to 00 for the watchdog tests
    for (int i = 0; i < 4; i++) field(10);
    ack = 1'b1;
    step();
    ack = 1'b0;
    field(10);
    field(10);
    outs("relock", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    // vsync coinciding with the saturated count wins
    repeat (400) ev(1'b0, 1'b1);
    ev(1'b1, 1'b0);
    outs("vs_wins", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (399) ev(1'b0, 1'b1);
    step();
    outs("cnt_clr", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    // strobe high masks all edges
    ndsync   = 1'b1;
    sync_pre = 4'hF;
    sync_cur = 4'h0;
    repeat (20) step();
    sync_cur = 4'hF;
    outs("nds_high", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    // 400th line without vsync declares loss on the following edge
    ev(1'b0, 1'b1);
    outs("line400", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    outs("lost", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
